// File: rtl/gpc_303_4.sv
// ============================================================================
// gpc_303_4 : (3,0,3;4) generalized parallel counter, dst = pc(src0) + 4*pc(src2)
// Optional output register: define GPC_303_4_OUTREG_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module gpc_303_4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] src0,
  input  logic [2:0] src2,
  output logic [3:0] dst
);

  logic [2:0] w_col [2];
  logic [1:0] w_cnt [2];
  logic [3:0] w_dst;

  assign w_col[0] = src0;
  assign w_col[1] = src2;

  // One full adder per column; the two column counts never interact.
  for (genvar g = 0; g < 2; g++) begin : g_fa
    assign w_cnt[g][0] = w_col[g][0] ^ w_col[g][1] ^ w_col[g][2];
    assign w_cnt[g][1] = (w_col[g][0] & w_col[g][1]) |
                         (w_col[g][0] & w_col[g][2]) |
                         (w_col[g][1] & w_col[g][2]);
  end

  assign w_dst = {w_cnt[1], w_cnt[0]};

`ifdef GPC_303_4_OUTREG_EN
  logic [3:0] r_dst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dst <= 4'h0;
    end else begin
      r_dst <= w_dst;
    end
  end

  assign dst = r_dst;
`else
  // Clock and reset stay on the port list so both builds share one interface.
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst};

  assign dst = w_dst;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gpc_303_4.sv
// Directed self-checking bench for gpc_303_4; adapts to GPC_303_4_OUTREG_EN.
`default_nettype none

module tb_gpc_303_4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] src0 = 3'b000;
  logic [2:0] src2 = 3'b000;
  logic [3:0] dst;

  int n_cmp = 0;
  int n_bad = 0;

  gpc_303_4 dut (
    .clk  (clk),
    .rst  (rst),
    .src0 (src0),
    .src2 (src2),
    .dst  (dst)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_sum(input logic [5:0] v);
    logic [3:0] s;
    s = 4'd0;
    for (int k = 0; k < 3; k++) begin
      s = s + {3'b000, v[k]};
      s = s + {1'b0, v[k+3], 2'b00};
    end
    return s;
  endfunction

`ifdef GPC_303_4_OUTREG_EN
  task automatic test_reset();
    rst = 1'b1;
    {src2, src0} = 6'h3f;
    #1;
    n_cmp++;
    if (dst !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_initial: got %h want %h", dst, 4'h0);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (dst !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_hold: got %h want %h", dst, 4'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    {src2, src0} = 6'h00;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    @(negedge clk);
    {src2, src0} = 6'h3f;
    #1;
    n_cmp++;
    if (dst !== 4'h0) begin
      n_bad++;
      $display("FAIL latency_early: got %h want %h", dst, 4'h0);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (dst !== 4'd15) begin
      n_bad++;
      $display("FAIL latency_3f: got %h want %h", dst, 4'd15);
    end
    @(negedge clk);
    {src2, src0} = 6'h09;
    #1;
    n_cmp++;
    if (dst !== 4'd15) begin
      n_bad++;
      $display("FAIL latency_hold: got %h want %h", dst, 4'd15);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (dst !== 4'd5) begin
      n_bad++;
      $display("FAIL latency_09: got %h want %h", dst, 4'd5);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    {src2, src0} = 6'h3f;
    @(posedge clk); #1;
    n_cmp++;
    if (dst !== 4'd15) begin
      n_bad++;
      $display("FAIL areset_pre: got %h want %h", dst, 4'd15);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (dst !== 4'h0) begin
      n_bad++;
      $display("FAIL areset_immediate: got %h want %h", dst, 4'h0);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (dst !== 4'h0) begin
        n_bad++;
        $display("FAIL areset_held%0d: got %h want %h", i, dst, 4'h0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    {src2, src0} = 6'h12;
    #1;
    n_cmp++;
    if (dst !== 4'h0) begin
      n_bad++;
      $display("FAIL areset_release: got %h want %h", dst, 4'h0);
    end
    // 6'h12 -> src2=010, src0=010 -> 4 + 1
    @(posedge clk); #1;
    n_cmp++;
    if (dst !== 4'd5) begin
      n_bad++;
      $display("FAIL areset_first: got %h want %h", dst, 4'd5);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      {src2, src0} = 6'(i);
      @(posedge clk); #1;
      {src2, src0} = 6'(63 - i);
      n_cmp++;
      if (dst !== ref_sum(6'(i))) begin
        n_bad++;
        $display("FAIL stream_%0d: got %h want %h", i, dst, ref_sum(6'(i)));
      end
    end
  endtask

  task automatic run_all();
    test_reset();
    test_latency();
    test_async_reset();
    test_back_to_back();
  endtask
`else
  task automatic test_reset();
    {src2, src0} = 6'h00;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (dst !== 4'h0) begin
      n_bad++;
      $display("FAIL comb_zero: got %h want %h", dst, 4'h0);
    end
    {src2, src0} = 6'h3f;
    #1;
    n_cmp++;
    if (dst !== 4'd15) begin
      n_bad++;
      $display("FAIL comb_rst_ignored: got %h want %h", dst, 4'd15);
    end
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 64; i++) begin
      {src2, src0} = 6'(i);
      #1;
      n_cmp++;
      if (dst !== ref_sum(6'(i))) begin
        n_bad++;
        $display("FAIL sweep_%02h: got %h want %h", i, dst, ref_sum(6'(i)));
      end
    end
  endtask

  task automatic test_isolation();
    logic [5:0] vin  [6];
    logic [3:0] vexp [6];
    vin[0] = 6'h00; vexp[0] = 4'd0;
    vin[1] = 6'h07; vexp[1] = 4'd3;
    vin[2] = 6'h38; vexp[2] = 4'd12;
    vin[3] = 6'h05; vexp[3] = 4'd2;
    vin[4] = 6'h18; vexp[4] = 4'd8;
    vin[5] = 6'h27; vexp[5] = 4'd7;
    for (int i = 0; i < 6; i++) begin
      {src2, src0} = vin[i];
      #1;
      n_cmp++;
      if (dst !== vexp[i]) begin
        n_bad++;
        $display("FAIL isolation_%02h: got %h want %h", vin[i], dst, vexp[i]);
      end
    end
  endtask

  task automatic test_permutation();
    for (int i = 0; i < 3; i++) begin
      src0 = 3'b000;
      src2 = 3'(1 << i);
      #1;
      n_cmp++;
      if (dst !== 4'd4) begin
        n_bad++;
        $display("FAIL perm_src2_%0d: got %h want %h", i, dst, 4'd4);
      end
      src2 = 3'b000;
      src0 = 3'(1 << i);
      #1;
      n_cmp++;
      if (dst !== 4'd1) begin
        n_bad++;
        $display("FAIL perm_src0_%0d: got %h want %h", i, dst, 4'd1);
      end
    end
  endtask

  task automatic run_all();
    test_reset();
    test_sweep();
    test_isolation();
    test_permutation();
  endtask
`endif

  initial begin
    run_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
